fft_output_reorder: RTL and testbench

- Sits at the tail of the 4-lane pipelined FFT, after the last butterfly/commutator stage.
- Accepts one frame of N bit-reversed-order results, 4 samples per cycle.
- Emits the same frame in natural order, 4 samples per cycle.
- Ping-pong storage lets one bank fill while the other drains, so back-to-back frames stream with no stall.

---
 rtl/fft_output_reorder.sv | 170 +++++++++++++++++
 tb/tb_fft_output_reorder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_output_reorder.sv
// fft_output_reorder
//   Tail stage of the 4-lane pipelined FFT. Takes one frame of N results in
//   bit-reversed order (4 samples per cycle) and emits it in natural order
//   (4 samples per cycle). Two banks ping-pong so one fills while the other
//   drains, letting back-to-back frames stream without a stall.
//
// Handshake: in_valid qualifies input_data for one cycle and there is no
//   backpressure, so the producer never waits. out_valid qualifies output_data
//   for one cycle and the consumer must take every valid beat. out_start marks
//   row 0 of each output frame.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        first row of an input frame (only with in_valid)
//   in_valid     input_data holds 4 samples this cycle
//   input_data   lane k at [nb*(k+1)-1 : nb*k], bit-reversed order
//   out_valid    output_data holds 4 samples this cycle
//   out_start    first row of an output frame
//   output_data  lane k at [nb*(k+1)-1 : nb*k], natural order
//   debug_state  read FSM state (1 = READ)

`ifndef FFTsfpw
`define FFTsfpw 16
`endif

module fft_output_reorder #(
    parameter int N = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [4*`FFTsfpw-1:0]  input_data,
    output logic                   out_valid,
    output logic                   out_start,
    output logic [4*`FFTsfpw-1:0]  output_data,
    output logic                   debug_state
);

    localparam int NB = `FFTsfpw;
    localparam int F  = N / 4;
    localparam int A  = $clog2(N);
    localparam int RW = A - 2;

    typedef enum logic {S_IDLE, S_READ} state_t;

    state_t          state, state_next;
    logic [RW-1:0]   wc, rc, rc_next;
    logic            wr_bank, rd_bank, rd_bank_next;
    logic [1:0]      full;
    logic [RW-1:0]   wr_row;
    logic            wr_last, rd_last;
    logic [4*NB-1:0] rd_row;

    // Storage contents are not reset; full flags decide what is readable.
    logic [NB-1:0]   mem [0:1][0:N-1];

    function automatic logic [A-1:0] bit_rev(input logic [A-1:0] v);
        logic [A-1:0] r;
        for (int i = 0; i < A; i++) r[i] = v[A-1-i];
        return r;
    endfunction

    // A start beat always lands in row 0, discarding any partial frame.
    assign wr_row  = start ? '0 : wc;
    assign wr_last = in_valid && (wr_row == RW'(F-1));
    assign rd_last = (state == S_READ) && (rc == RW'(F-1));

    assign debug_state = (state == S_READ);

    // ---------------- write side ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wc      <= '0;
            wr_bank <= 1'b0;
        end else if (in_valid) begin
            if (wr_last) begin
                wc      <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wc <= wr_row + RW'(1);
            end
        end
    end

    // Lane k of row c holds X[bitrev(4c+k)]; store it at its natural index.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int k = 0; k < 4; k++)
                mem[wr_bank][bit_rev({wr_row, 2'(k)})] <= input_data[NB*k +: NB];
        end
    end

    // Clear before set: a bank is never drained and refilled in one cycle,
    // but the ordering keeps "full" authoritative if that were ever to happen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full <= 2'b00;
        end else begin
            if (rd_last) full[rd_bank] <= 1'b0;
            if (wr_last) full[wr_bank] <= 1'b1;
        end
    end

    // ---------------- read side ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            rc      <= '0;
            rd_bank <= 1'b0;
        end else begin
            state   <= state_next;
            rc      <= rc_next;
            rd_bank <= rd_bank_next;
        end
    end

    // Banks fill and drain in the same alternating order, so the read bank
    // simply follows its own toggle rather than searching for a full bank.
    always_comb begin
        state_next   = state;
        rc_next      = rc;
        rd_bank_next = rd_bank;
        case (state)
            S_IDLE: begin
                if (full[rd_bank]) begin
                    state_next = S_READ;
                    rc_next    = '0;
                end
            end
            S_READ: begin
                if (rc == RW'(F-1)) begin
                    rd_bank_next = ~rd_bank;
                    rc_next      = '0;
                    // The registered flag of the other bank decides whether
                    // the next frame follows with no gap.
                    if (!full[~rd_bank]) state_next = S_IDLE;
                end else begin
                    rc_next = rc + RW'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        rd_row = '0;
        for (int k = 0; k < 4; k++)
            rd_row[NB*k +: NB] = mem[rd_bank][{rc, 2'(k)}];
    end

    // ---------------- output registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_start   <= 1'b0;
            output_data <= '0;
        end else if (state == S_READ) begin
            out_valid   <= 1'b1;
            out_start   <= (rc == '0);
            output_data <= rd_row;
        end else begin
            out_valid   <= 1'b0;
            out_start   <= 1'b0;
            output_data <= '0;
        end
    end

endmodule

// File: tb/tb_fft_output_reorder.sv
// Testbench for fft_output_reorder: directed frames against an expected
// output schedule (indexed by cycle) built from natural-order frame data.

`ifndef FFTsfpw
`define FFTsfpw 16
`endif

module tb_fft_output_reorder;

    localparam int NB   = `FFTsfpw;
    localparam int MAXC = 4096;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    logic start;
    logic in_valid;
    logic [4*NB-1:0] input_data;

    always #5 clk = ~clk;

    logic            ov16, os16, st16;
    logic [4*NB-1:0] od16;
    logic            ov64, os64, st64;
    logic [4*NB-1:0] od64;

    fft_output_reorder #(.N(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
        .input_data(input_data), .out_valid(ov16), .out_start(os16),
        .output_data(od16), .debug_state(st16)
    );

    fft_output_reorder #(.N(64)) dut64 (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
        .input_data(input_data), .out_valid(ov64), .out_start(os64),
        .output_data(od64), .debug_state(st64)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    int cyc    = -1;
    bit use64  = 1'b0;
    int fr     = 4;
    int ab     = 4;

    logic            exp_v [MAXC];
    logic            exp_s [MAXC];
    logic [4*NB-1:0] exp_d [MAXC];
    logic [NB-1:0]   x     [256];

    task automatic check(input string tag, input logic [4*NB-1:0] got, input logic [4*NB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int bit_rev(input int v, input int bits);
        int r = 0;
        for (int i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    task automatic clear_exp();
        for (int i = 0; i < MAXC; i++) begin
            exp_v[i] = 1'b0;
            exp_s[i] = 1'b0;
            exp_d[i] = '0;
        end
    endtask

    task automatic check_outputs(input string pfx);
        logic            ov, os, st;
        logic [4*NB-1:0] od;
        ov = use64 ? ov64 : ov16;
        os = use64 ? os64 : os16;
        od = use64 ? od64 : od16;
        st = use64 ? st64 : st16;
        check($sformatf("%s valid c%0d", pfx, cyc), {{(4*NB-1){1'b0}}, ov}, {{(4*NB-1){1'b0}}, exp_v[cyc]});
        check($sformatf("%s start c%0d", pfx, cyc), {{(4*NB-1){1'b0}}, os}, {{(4*NB-1){1'b0}}, exp_s[cyc]});
        check($sformatf("%s data c%0d",  pfx, cyc), od, exp_d[cyc]);
        // READ in this cycle means a valid output row on the next one.
        check($sformatf("%s state c%0d", pfx, cyc), {{(4*NB-1){1'b0}}, st}, {{(4*NB-1){1'b0}}, exp_v[cyc+1]});
    endtask

    // ---------------- driver ----------------
    task automatic tick(input logic s, input logic v, input logic [4*NB-1:0] d);
        @(negedge clk);
        start      = s;
        in_valid   = v;
        input_data = d;
        @(posedge clk);
        cyc++;
        #1;
        check_outputs("out");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0);
    endtask

    task automatic fill_seq(input int base);
        for (int i = 0; i < 256; i++) x[i] = NB'(base + i);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 256; i++) x[i] = NB'($urandom_range(0, 65535));
    endtask

    task automatic drive_row(input int c, input logic s);
        logic [4*NB-1:0] d;
        for (int k = 0; k < 4; k++) d[NB*k +: NB] = x[bit_rev(4*c + k, ab)];
        tick(s, 1'b1, d);
    endtask

    // Sends x[] as one frame; optional gap (start=1, in_valid=0, junk data)
    // after row gap_row. Schedules natural-order rows at T+2.
    task automatic send_frame(input int gap_row, input int gap_len);
        int t;
        for (int c = 0; c < fr; c++) begin
            drive_row(c, c == 0);
            if (c == gap_row)
                for (int g = 0; g < gap_len; g++) tick(1'b1, 1'b0, {(4*NB){1'b1}});
        end
        t = cyc;
        for (int r = 0; r < fr; r++) begin
            exp_v[t+2+r] = 1'b1;
            exp_s[t+2+r] = (r == 0);
            for (int k = 0; k < 4; k++) exp_d[t+2+r][NB*k +: NB] = x[4*r + k];
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        clear_exp();
        tick(1'b0, 1'b0, '0);
        reset_n = 1'b1;
    endtask

    // Hand-written vectors for the first frame.
    int in_tab  [4][4] = '{'{0, 8, 4, 12}, '{2, 10, 6, 14}, '{1, 9, 5, 13}, '{3, 11, 7, 15}};
    int out_tab [4][4] = '{'{0, 1, 2, 3}, '{4, 5, 6, 7}, '{8, 9, 10, 11}, '{12, 13, 14, 15}};

    initial begin
        logic [4*NB-1:0] d;
        int t0;

        clear_exp();
        reset_n    = 1'b0;
        start      = 1'b0;
        in_valid   = 1'b0;
        input_data = '0;
        #2;
        check("reset valid", {{(4*NB-1){1'b0}}, ov16}, '0);
        check("reset start", {{(4*NB-1){1'b0}}, os16}, '0);
        check("reset data",  od16, '0);
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
        reset_n = 1'b1;
        idle(2);

        // Test 1: single frame from the hand table; out_start 5 cycles later.
        t0 = cyc + 1;
        for (int r = 0; r < 4; r++) begin
            exp_v[t0+5+r] = 1'b1;
            exp_s[t0+5+r] = (r == 0);
            for (int k = 0; k < 4; k++) exp_d[t0+5+r][NB*k +: NB] = NB'(out_tab[r][k]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) d[NB*k +: NB] = NB'(in_tab[c][k]);
            tick(c == 0, 1'b1, d);
        end
        idle(8);

        // Test 2: three back-to-back frames, data = frame*16 + index.
        for (int f = 0; f < 3; f++) begin
            fill_seq(f * 16);
            send_frame(-1, 0);
        end
        idle(8);

        // Test 3: gap of 3 cycles between rows 1 and 2 (start without in_valid).
        fill_seq(0);
        send_frame(1, 3);
        idle(8);

        // Test 4: 2 rows of an abandoned frame, then a restarted frame.
        fill_seq(16'h0100);
        drive_row(0, 1'b1);
        drive_row(1, 1'b0);
        fill_seq(16'h0200);
        send_frame(-1, 0);
        idle(8);

        // Test 5: reset asserted during output row 2.
        fill_seq(16'h0300);
        send_frame(-1, 0);
        idle(4);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst valid", {{(4*NB-1){1'b0}}, ov16}, '0);
        check("midrst start", {{(4*NB-1){1'b0}}, os16}, '0);
        check("midrst data",  od16, '0);
        clear_exp();
        tick(1'b0, 1'b0, '0);
        reset_n = 1'b1;
        idle(8);
        fill_seq(16'h0400);
        send_frame(-1, 0);
        idle(8);

        // Test 6: N=64, four back-to-back random frames.
        use64 = 1'b1;
        fr    = 16;
        ab    = 6;
        pulse_reset();
        idle(2);
        for (int f = 0; f < 4; f++) begin
            fill_rand();
            send_frame(-1, 0);
        end
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
